// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci engine front-end.
package fib_pkg;

    localparam int FIB_W     = 16;
    localparam int FIB_MAX_N = 24;
    localparam logic [FIB_W-1:0] FIB_ERR_VALUE = 16'hFFFF;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_LAUNCH,
        DISP_WAIT,
        DISP_PUSH
    } fib_disp_state_t;

    typedef struct packed {
        logic             err;
        logic [FIB_W-1:0] data;
    } fib_result_t;

endpackage

// File: rtl/fib_result_fifo.sv
// Result FIFO for fib_dispatch. DEPTH must be a power of two, so the pointers wrap naturally.
module fib_result_fifo
    import fib_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  fib_result_t            push_data_i,
    input  logic                   pop_i,
    output fib_result_t            head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    fib_result_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Storage is not reset, so the head is forced to zero while empty.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fib_dispatch.sv
// Single-job request front-end for the Fibonacci engine, with a result FIFO.
// Optional FIB_DISPATCH_RANGE_CHECK_EN: indices above FIB_MAX_N are rejected without launching.
//
// state  | meaning
// IDLE   | ready for a request when the FIFO has a free slot
// LAUNCH | one-cycle fib_start pulse, wait timer cleared
// WAIT   | waiting for fib_done (ignored in the first cycle) or timeout
// PUSH   | captured result written into the FIFO
module fib_dispatch
    import fib_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [FIB_W-1:0] req_n,
    output logic             fib_start,
    output logic [FIB_W-1:0] fib_din,
    input  logic [FIB_W-1:0] fib_dout,
    input  logic             fib_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [FIB_W-1:0] res_data,
    output logic             res_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    fib_disp_state_t  state_q, state_d;
    logic [FIB_W-1:0] din_q, din_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    fib_result_t      res_q, res_d;
    logic             push;

    fib_result_t      fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign req_ready = (state_q == DISP_IDLE) && (fifo_count < CNT_W'(DEPTH));
    assign busy      = (state_q != DISP_IDLE);
    assign fib_din   = din_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DISP_IDLE;
            din_q   <= '0;
            timer_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            timer_q <= timer_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        din_d     = din_q;
        timer_d   = timer_q;
        res_d     = res_q;
        fib_start = 1'b0;
        push      = 1'b0;
        case (state_q)
            DISP_IDLE: begin
                if (req_valid && req_ready) begin
                    din_d   = req_n;
                    state_d = DISP_LAUNCH;
`ifdef FIB_DISPATCH_RANGE_CHECK_EN
                    if (req_n > FIB_W'(FIB_MAX_N)) begin
                        res_d   = '{err: 1'b1, data: FIB_ERR_VALUE};
                        state_d = DISP_PUSH;
                    end
`endif
                end
            end
            DISP_LAUNCH: begin
                fib_start = 1'b1;
                timer_d   = '0;
                state_d   = DISP_WAIT;
            end
            DISP_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // timer_q == 0 marks the first WAIT cycle, where done may be left over from the last job
                if (fib_done && (timer_q != '0)) begin
                    res_d   = '{err: 1'b0, data: fib_dout};
                    state_d = DISP_PUSH;
                end else if (timer_q == TMR_LAST) begin
                    res_d   = '{err: 1'b1, data: FIB_ERR_VALUE};
                    state_d = DISP_PUSH;
                end
            end
            DISP_PUSH: begin
                push    = !fifo_full;
                state_d = DISP_IDLE;
            end
            default: begin
                state_d = DISP_IDLE;
            end
        endcase
    end

    fib_result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_data_i(res_q),
        .pop_i      (res_valid && res_ready),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign res_valid = !fifo_empty;
    assign res_data  = fifo_head.data;
    assign res_err   = fifo_head.err;

endmodule

// File: tb/tb_fib_dispatch.sv
// Self-checking bench for fib_dispatch: engine model, result scoreboard, directed and random traffic.
module tb_fib_dispatch;
    import fib_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
`ifdef FIB_DISPATCH_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_n = '0;
    logic        fib_start;
    logic [15:0] fib_din;
    logic [15:0] fib_dout = '0;
    logic        fib_done = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_err;
    logic        busy;

    fib_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
        .fib_start(fib_start), .fib_din(fib_din), .fib_dout(fib_dout), .fib_done(fib_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int drain = 0;
    int lat_fixed = 0;
    bit eng_hang = 1'b0;
    bit acc_hang = 1'b0;
    int acc_cyc = 0;
    int start_cnt = 0;
    bit prev_launch = 1'b0;
    logic [15:0] last_n = '0;

    typedef struct {
        bit          err;
        logic [15:0] data;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        exp_cur;
    logic [15:0] pop_log[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [15:0] fib_ref(input int n);
        logic [15:0] a, b, t;
        a = 16'd0;
        b = 16'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic bit launches(input logic [15:0] n);
        return !RANGE_EN || (n <= 16'd24);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Engine model: done is sticky until two cycles after the next start, with garbage data meanwhile.
    int          since = 1000;
    int          lat = 3;
    bit          job_hang = 1'b0;
    logic [15:0] job_n = '0;
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            since = 1000;
            fib_done = 1'b0;
        end else begin
            if (fib_start) begin
                since = 0;
                job_n = fib_din;
                job_hang = acc_hang;
                lat = (lat_fixed > 0) ? lat_fixed : $urandom_range(2, 8);
            end else if (since < 1000) begin
                since++;
            end
            if (since < 2) begin
                fib_dout = 16'hDEAD;
            end else if (!job_hang && since >= lat) begin
                fib_done = 1'b1;
                fib_dout = fib_ref(int'(job_n));
            end else begin
                fib_done = 1'b0;
                fib_dout = 16'($urandom);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (drain)
            0: res_ready = 1'b0;
            1: res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard: expectations are formed at accept, compared at pop.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            exp_q.delete();
            prev_launch = 1'b0;
        end else begin
            chk("fib_start_timing", fib_start, prev_launch);
            if (fib_start) start_cnt++;
            if (busy) chk("fib_din_hold", fib_din, last_n);
            if (exp_q.size() == 0) chk("res_valid_when_empty", res_valid, 0);
            if (res_valid && res_ready && exp_q.size() > 0) begin
                exp_cur = exp_q.pop_front();
                chk("res_data", res_data, exp_cur.data);
                chk("res_err", res_err, exp_cur.err);
                pop_log.push_back(res_data);
            end
            prev_launch = 1'b0;
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                last_n = req_n;
                acc_hang = eng_hang;
                prev_launch = launches(req_n);
                exp_cur.err = !launches(req_n) || eng_hang;
                exp_cur.data = exp_cur.err ? 16'hFFFF : fib_ref(int'(req_n));
                exp_q.push_back(exp_cur);
            end
        end
    end

    task automatic send(input logic [15:0] n);
        bit got;
        got = 1'b0;
        req_n = n;
        req_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!got) begin
            n_total++;
            $display("FAIL send_accept: req_ready never high for n=%0d, required 1", n);
        end
    endtask

    task automatic wait_valid(output int at_cyc);
        bit ok;
        ok = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL wait_valid: res_valid stayed 0, required 1");
        end
    endtask

    task automatic wait_drained();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        chk("drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int a_c, t_c, s0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_fib_start", fib_start, 0);
        chk("rst_fib_din", fib_din, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_busy", busy, 0);
        chk("model_fib10", fib_ref(10), 55);
        chk("model_fib24", fib_ref(24), 46368);
        chk("model_fib25", fib_ref(25), 9489);
        @(posedge clk);
        #1;

        // Single job, fixed engine latency
        drain = 0;
        lat_fixed = 4;
        s0 = start_cnt;
        send(16'd10);
        a_c = acc_cyc;
        wait_valid(t_c);
        chk("t1_valid_cycle", t_c, a_c + 3 + 4);
        chk("t1_data", res_data, 55);
        chk("t1_err", res_err, 0);
        chk("t1_starts", start_cnt - s0, 1);
        @(posedge clk);
        #1;
        drain = 1;
        wait_drained();

        // Back-to-back requests with stale done
        lat_fixed = 0;
        pop_log.delete();
        s0 = start_cnt;
        send(16'd0);
        send(16'd1);
        send(16'd2);
        wait_drained();
        chk("t2_starts", start_cnt - s0, 3);
        chk("t2_count", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            chk("t2_r0", pop_log[0], 0);
            chk("t2_r1", pop_log[1], 1);
            chk("t2_r2", pop_log[2], 1);
        end

        // FIFO full backpressure
        drain = 0;
        idle(2);
        pop_log.delete();
        for (int i = 3; i <= 6; i++) send(16'(i));
        idle(16);
        @(negedge clk);
        chk("t3_full_req_ready", req_ready, 0);
        chk("t3_full_res_valid", res_valid, 1);
        chk("t3_full_busy", busy, 0);
        @(posedge clk);
        #1;
        drain = 1;
        idle(2);
        @(negedge clk);
        chk("t3_drain_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        send(16'd7);
        wait_drained();
        chk("t3_count", pop_log.size(), 5);
        if (pop_log.size() == 5) begin
            chk("t3_r0", pop_log[0], 2);
            chk("t3_r1", pop_log[1], 3);
            chk("t3_r2", pop_log[2], 5);
            chk("t3_r3", pop_log[3], 8);
            chk("t3_r4", pop_log[4], 13);
        end

        // Engine never completes
        drain = 0;
        idle(2);
        eng_hang = 1'b1;
        send(16'd7);
        a_c = acc_cyc;
        wait_valid(t_c);
        chk("t4_valid_cycle", t_c, a_c + 3 + TIMEOUT);
        chk("t4_data", res_data, 16'hFFFF);
        chk("t4_err", res_err, 1);
        chk("t4_busy", busy, 0);
        @(posedge clk);
        #1;
        eng_hang = 1'b0;
        drain = 1;
        wait_drained();

        // Out-of-range index
        drain = 0;
        idle(2);
        s0 = start_cnt;
        send(16'd25);
        wait_valid(t_c);
        chk("t5_starts", start_cnt - s0, RANGE_EN ? 0 : 1);
        chk("t5_data", res_data, RANGE_EN ? 16'hFFFF : 16'd9489);
        chk("t5_err", res_err, RANGE_EN ? 1 : 0);
        @(posedge clk);
        #1;
        drain = 1;
        wait_drained();

        // Reset in the middle of WAIT with two results queued
        drain = 0;
        idle(2);
        lat_fixed = 2;
        send(16'd8);
        send(16'd9);
        idle(8);
        lat_fixed = 30;
        send(16'd11);
        idle(5);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_fib_start", fib_start, 0);
        chk("t6_rst_fib_din", fib_din, 0);
        chk("t6_rst_res_valid", res_valid, 0);
        chk("t6_rst_res_data", res_data, 0);
        chk("t6_rst_res_err", res_err, 0);
        chk("t6_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_req_ready", req_ready, 1);
        chk("t6_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        lat_fixed = 0;
        drain = 1;
        pop_log.delete();
        send(16'd5);
        wait_drained();
        chk("t6_count", pop_log.size(), 1);
        if (pop_log.size() == 1) chk("t6_r0", pop_log[0], 5);

        // Random traffic
        drain = 2;
        for (int i = 0; i < 60; i++) begin
            eng_hang = ($urandom_range(0, 11) == 0);
            idle($urandom_range(0, 2));
            send(16'($urandom_range(0, 40)));
        end
        eng_hang = 1'b0;
        drain = 1;
        wait_drained();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
